// File: rtl/mdu_seq.sv
// Iterative RV64M multiply/divide sequencer beside the execute-stage ALU.
// Latency: accept->done 67 cycles (64-bit), 35 (W ops), 3 (div special cases / illegal op).
// Backpressure: one op in flight; ready only in IDLE, busy stalls execute, flush aborts.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   valid, ready   request handshake (accept = valid & ready & !flush)
//   op, a, b       operation code and rs1/rs2 operands
//   flush          abort in-flight operation (no done, result unchanged)
//   busy           high in every state except IDLE
//   done, result   one-cycle completion pulse and held 64-bit result
module mdu_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid,
  output logic            ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [3:0] OP_MUL   = 4'd0;
  localparam logic [3:0] OP_DIV   = 4'd1;
  localparam logic [3:0] OP_REM   = 4'd3;
  localparam logic [3:0] OP_REMU  = 4'd4;
  localparam logic [3:0] OP_MULW  = 4'd5;
  localparam logic [3:0] OP_DIVW  = 4'd6;
  localparam logic [3:0] OP_REMW  = 4'd8;
  localparam logic [3:0] OP_REMUW = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t state, state_n;

  // Latched request
  logic [3:0]      op_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;

  // Iteration datapath. MUL: acc = partial product, mcand = shifted
  // multiplicand, mq = multiplier shifting right. DIV: acc = partial
  // remainder, mcand = divisor, mq = dividend shifting out at the top
  // while quotient bits shift in at the bottom.
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mq;
  logic [6:0]      cnt;
  logic            neg_q;     // quotient must be negated
  logic            neg_r;     // remainder must be negated
  logic            spec;      // result comes from spec_res, not the datapath
  logic [XLEN-1:0] spec_res;

  // Operation decode (from latched op)
  logic is_mul, is_w, is_sgn, is_rem, is_legal;

  always_comb begin
    is_mul   = (op_q == OP_MUL) || (op_q == OP_MULW);
    is_w     = (op_q >= OP_MULW) && (op_q <= OP_REMUW);
    is_sgn   = (op_q == OP_DIV) || (op_q == OP_REM) ||
               (op_q == OP_DIVW) || (op_q == OP_REMW);
    is_rem   = (op_q == OP_REM) || (op_q == OP_REMU) ||
               (op_q == OP_REMW) || (op_q == OP_REMUW);
    is_legal = (op_q <= OP_REMUW);
  end

  // Operand preparation: width truncation/extension, magnitudes, special cases
  logic [XLEN-1:0] aw, bw, abs_a, abs_b, min_val, spec_val;
  logic            sa, sb, div0, ovf, spec_hit;

  always_comb begin
    aw = a_q;
    bw = b_q;
    if (is_w) begin
      if (is_sgn) begin
        aw = {{(XLEN-32){a_q[31]}}, a_q[31:0]};
        bw = {{(XLEN-32){b_q[31]}}, b_q[31:0]};
      end else begin
        aw = {{(XLEN-32){1'b0}}, a_q[31:0]};
        bw = {{(XLEN-32){1'b0}}, b_q[31:0]};
      end
    end
    sa    = is_sgn & aw[XLEN-1];
    sb    = is_sgn & bw[XLEN-1];
    abs_a = sa ? (~aw + 1'b1) : aw;
    abs_b = sb ? (~bw + 1'b1) : bw;

    // Most-negative value of the op width, as it appears after sign extension
    min_val = is_w ? {{(XLEN-31){1'b1}}, 31'h0} : {1'b1, {(XLEN-1){1'b0}}};
    div0    = !is_mul && (bw == '0);
    ovf     = is_sgn && (aw == min_val) && (bw == '1);
    spec_hit = !is_legal || div0 || ovf;

    spec_val = '0;
    if (!is_legal) begin
      spec_val = '0;
    end else if (div0) begin
      spec_val = is_rem ? aw : '1;
    end else if (ovf) begin
      spec_val = is_rem ? '0 : aw;
    end
  end

  // One iteration step
  logic [XLEN:0]   r_sh, diff;
  logic [XLEN-1:0] acc_step, mcand_step, mq_step;

  always_comb begin
    r_sh       = {acc, mq[XLEN-1]};
    diff       = r_sh - {1'b0, mcand};
    acc_step   = acc;
    mcand_step = mcand;
    mq_step    = mq;
    if (is_mul) begin
      acc_step   = mq[0] ? (acc + mcand) : acc;
      mcand_step = {mcand[XLEN-2:0], 1'b0};
      mq_step    = {1'b0, mq[XLEN-1:1]};
    end else if (!diff[XLEN]) begin
      // Trial subtraction did not go negative: keep it, quotient bit 1
      acc_step = diff[XLEN-1:0];
      mq_step  = {mq[XLEN-2:0], 1'b1};
    end else begin
      acc_step = r_sh[XLEN-1:0];
      mq_step  = {mq[XLEN-2:0], 1'b0};
    end
  end

  // Final sign correction and width selection
  logic [XLEN-1:0] base, fixed;
  logic            neg;

  always_comb begin
    base  = (is_mul || is_rem) ? acc : mq;
    neg   = !is_mul && (is_rem ? neg_r : neg_q);
    fixed = neg ? (~base + 1'b1) : base;
    if (spec) begin
      fixed = spec_res;
    end
    if (is_w) begin
      fixed = {{(XLEN-32){fixed[31]}}, fixed[31:0]};
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (valid && !flush) state_n = S_PREP;
      S_PREP: state_n = spec_hit ? S_FIX : S_ITER;
      S_ITER: if (cnt == 7'd1) state_n = S_FIX;
      S_FIX:  state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    // DONE completes regardless of flush; every other busy state aborts
    if (flush && (state != S_IDLE) && (state != S_DONE)) begin
      state_n = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mq       <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      spec     <= 1'b0;
      spec_res <= '0;
      result   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (valid && !flush) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
          end
        end
        S_PREP: begin
          acc      <= '0;
          cnt      <= is_w ? 7'd32 : 7'd64;
          spec     <= spec_hit;
          spec_res <= spec_val;
          neg_q    <= sa ^ sb;
          neg_r    <= sa;
          if (is_mul) begin
            // Low product bits are signedness-independent: use raw operands
            mcand <= aw;
            mq    <= bw;
          end else begin
            mcand <= abs_b;
            // W dividends are left-aligned so 32 shifts consume exactly them
            mq    <= is_w ? {abs_a[31:0], {(XLEN-32){1'b0}}} : abs_a;
          end
        end
        S_ITER: begin
          acc   <= acc_step;
          mcand <= mcand_step;
          mq    <= mq_step;
          cnt   <= cnt - 7'd1;
        end
        S_FIX: begin
          if (!flush) begin
            result <= fixed;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready = (state == S_IDLE);
  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);

endmodule
